// File: rtl/sc_mac_pkg.sv
// Shared types and defaults for the stochastic MAC controller: FSM state enum,
// default stream/pipeline sizing, result width and the length-exponent clamp.
package sc_mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int MAX_LOG2_DEF = 8;
   localparam int PIPE_LAT_DEF = 2;
   localparam int RES_W_DEF    = MAX_LOG2_DEF + 2;
   localparam int MIN_LOG2     = 4;

   // Shortest stream is 16 bits; anything longer than the counters allow is cut down.
   function automatic int clamp_log2(input logic [3:0] len, input int max_log2);
      int v;
      v = int'(len);
      if (v < MIN_LOG2) v = MIN_LOG2;
      if (v > max_log2) v = max_log2;
      return v;
   endfunction

endpackage

// File: rtl/sc_bit_counter.sv
// Saturating ones counter: one cycle from bit_i to count_o, holds at max_i.
// No backpressure; clr_i has priority over en_i.
module sc_bit_counter #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic         bit_i,
   input  logic [W-1:0] max_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (en_i && bit_i && (count_q < max_i)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/sc_mac_ctrl.sv
// Stochastic MAC sequencer: LOAD (1 cycle), RUN (PIPE_LAT+L cycles), then DONE holding
// the bipolar result until res_ready; start_ready only in IDLE, abort drops the run.
module sc_mac_ctrl
   import sc_mac_pkg::*;
#(
   parameter int MAX_LOG2 = MAX_LOG2_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_valid,
   output logic                      start_ready,
   input  logic [3:0]                len_log2,
   input  logic                      abort,
   output logic                      load_a,
   output logic                      load_b,
   output logic                      rng_clr,
   output logic                      rng_en,
   input  logic                      mac_bit,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic signed [MAX_LOG2+1:0] result,
   output logic                      busy
);

   localparam int W  = MAX_LOG2 + 1;
   localparam int RW = MAX_LOG2 + 2;
   localparam int CW = $clog2(PIPE_LAT + (2 ** MAX_LOG2)) + 1;
   localparam logic [CW-1:0] PL = CW'(PIPE_LAT);

   state_t               state_q;
   logic [W-1:0]         len_q;
   logic [CW-1:0]        cyc_q;
   logic [W-1:0]         ones_q;
   logic                 load_q;
   logic                 rng_clr_q;
   logic                 rng_en_q;
   logic                 res_valid_q;
   logic signed [RW-1:0] result_q;
   logic signed [RW-1:0] result_d;
   logic [W-1:0]         l_new;
   logic [W-1:0]         ones_final;
   logic [RW:0]          diff;
   logic [CW-1:0]        last_idx;
   logic                 cnt_en;

   assign l_new    = W'(1) << clamp_log2(len_log2, MAX_LOG2);
   assign last_idx = PL + CW'(len_q) - CW'(1);
   assign cnt_en   = (state_q == ST_RUN) && (cyc_q >= PL);

   sc_bit_counter #(.W(W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (state_q == ST_LOAD),
      .en_i    (cnt_en),
      .bit_i   (mac_bit),
      .max_i   (len_q),
      .count_o (ones_q)
   );

   // The last counted bit is still in flight on the final RUN cycle, so fold it in here.
   assign ones_final = ones_q + W'(mac_bit);
   assign diff       = {1'b0, ones_final, 1'b0} - {2'b00, len_q};
   assign result_d   = $signed(diff[RW-1:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         cyc_q       <= '0;
         result_q    <= '0;
         res_valid_q <= 1'b0;
         load_q      <= 1'b0;
         rng_clr_q   <= 1'b0;
         rng_en_q    <= 1'b0;
      end else begin
         load_q    <= 1'b0;
         rng_clr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_valid) begin
                  len_q     <= l_new;
                  state_q   <= ST_LOAD;
                  load_q    <= 1'b1;
                  rng_clr_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               cyc_q <= '0;
               if (abort) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q  <= ST_RUN;
                  rng_en_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_q  <= ST_IDLE;
                  rng_en_q <= 1'b0;
               end else if (cyc_q == last_idx) begin
                  state_q     <= ST_DONE;
                  rng_en_q    <= 1'b0;
                  result_q    <= result_d;
                  res_valid_q <= 1'b1;
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  state_q     <= ST_IDLE;
                  res_valid_q <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign start_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign load_a      = load_q;
   assign load_b      = load_q;
   assign rng_clr     = rng_clr_q;
   assign rng_en      = rng_en_q;
   assign res_valid   = res_valid_q;
   assign result      = result_q;

endmodule

// File: tb/tb_sc_mac_ctrl.sv
// Directed bench for sc_mac_ctrl; expected results queue into a scoreboard drained by a monitor.
module tb_sc_mac_ctrl;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_valid;
   logic              start_ready;
   logic [3:0]        len_log2;
   logic              abort;
   logic              load_a, load_b, rng_clr, rng_en;
   logic              mac_bit;
   logic              res_valid;
   logic              res_ready;
   logic signed [9:0] result;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_q[$];
   int mon_exp;

   always #5 clk = ~clk;

   sc_mac_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .len_log2    (len_log2),
      .abort       (abort),
      .load_a      (load_a),
      .load_b      (load_b),
      .rng_clr     (rng_clr),
      .rng_en      (rng_en),
      .mac_bit     (mac_bit),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .result      (result),
      .busy        (busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every result handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_result: got %0d, nothing expected", int'(result));
         end else begin
            mon_exp = exp_q.pop_front();
            if (int'(result) != mon_exp) begin
               n_bad++;
               $display("FAIL result: got %0d, expected %0d", int'(result), mon_exp);
            end
         end
      end
   end

   // k = cycles since acceptance: 0 is LOAD, 1..2 skipped RUN cycles, 3.. counted.
   function automatic logic pat(input int kind, input int k);
      int j;
      j = k - 3;
      case (kind)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (k < 3) ? 1'b1 : ((j % 4) != 3);
         default: return (k < 3) ? 1'b0 : ((j % 2) == 0);
      endcase
   endfunction

   task automatic do_start(input logic [3:0] len);
      int t;
      t = 0;
      len_log2    = len;
      start_valid = 1'b1;
      while (!start_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t == 50) chk("start_timeout", 0, 1);
      @(posedge clk); #1;
      start_valid = 1'b0;
   endtask

   // Entered #1 after the acceptance edge; ends #1 after the DONE (or abort) edge.
   task automatic run_stream(input int L, input int kind, input int abort_k);
      for (int k = 0; k <= L + 2; k++) begin
         mac_bit = pat(kind, k);
         abort   = (k == abort_k);
         if (k == 0) begin
            chk("load_a_in_load", int'(load_a), 1);
            chk("load_b_in_load", int'(load_b), 1);
            chk("rng_clr_in_load", int'(rng_clr), 1);
            chk("rng_en_in_load", int'(rng_en), 0);
            chk("busy_in_load", int'(busy), 1);
         end
         if (k == 1) begin
            chk("load_a_in_run", int'(load_a), 0);
            chk("rng_en_in_run", int'(rng_en), 1);
         end
         if (k == L + 2) chk("valid_before_end", int'(res_valid), 0);
         @(posedge clk); #1;
         if (k == abort_k) break;
      end
      abort   = 1'b0;
      mac_bit = 1'b0;
      if (abort_k < 0) begin
         chk("valid_at_latency", int'(res_valid), 1);
      end else begin
         chk("abort_no_valid", int'(res_valid), 0);
         chk("abort_start_ready", int'(start_ready), 1);
         chk("abort_rng_en", int'(rng_en), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start_valid = 1'b0; len_log2 = 4'd0; abort = 1'b0;
      mac_bit = 1'b0; res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_load_a", int'(load_a), 0);
      chk("rst_rng_clr", int'(rng_clr), 0);
      chk("rst_rng_en", int'(rng_en), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("start_ready_after_rst", int'(start_ready), 1);

      exp_q.push_back(256);  do_start(4'd8);  run_stream(256, 0, -1);
      exp_q.push_back(-256); do_start(4'd8);  run_stream(256, 1, -1);
      exp_q.push_back(8);    do_start(4'd4);  run_stream(16, 2, -1);
      exp_q.push_back(0);    do_start(4'd15); run_stream(256, 3, -1);
      exp_q.push_back(16);   do_start(4'd0);  run_stream(16, 0, -1);

      do_start(4'd4); run_stream(16, 0, 18);
      repeat (3) @(posedge clk);
      #1 chk("abort_quiet", int'(res_valid), 0);
      do_start(4'd4); run_stream(16, 0, 0);
      chk("abort_load_busy", int'(busy), 0);

      // Consumer stalls in DONE while a competing start is held high.
      res_ready = 1'b0;
      exp_q.push_back(16);
      do_start(4'd4); run_stream(16, 0, -1);
      start_valid = 1'b1;
      len_log2    = 4'd4;
      for (int i = 0; i < 10; i++) begin
         chk("hold_result", int'(result), 16);
         chk("hold_valid", int'(res_valid), 1);
         chk("hold_start_ready", int'(start_ready), 0);
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_hs", int'(busy), 0);
      chk("ready_after_hs", int'(start_ready), 1);
      exp_q.push_back(-16);
      @(posedge clk); #1;
      start_valid = 1'b0;
      run_stream(16, 1, -1);

      do_start(4'd4);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_run_busy", int'(busy), 0);
      chk("rst_run_rng_en", int'(rng_en), 0);
      repeat (25) @(posedge clk);
      #1 chk("rst_run_no_valid", int'(res_valid), 0);

      res_ready = 1'b0;
      do_start(4'd4); run_stream(16, 0, -1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      res_ready = 1'b1;
      chk("rst_done_valid", int'(res_valid), 0);
      chk("rst_done_result", int'(result), 0);
      repeat (5) @(posedge clk);
      #1 chk("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
